hyper_trans_sched: RTL

Transaction scheduler between the HyperBus uDMA register interface and the HyperBus PHY/command engine.
- Accepts one transaction descriptor at a time: external address, byte size, direction, mode, plus 2D stride/line.
- Splits each transaction into PHY bursts so that no burst exceeds the chip-select maximum (cs_max) or crosses a 2D line end.
- Advances addresses per burst and per 2D line; reports busy and completion.

---
 rtl/hyper_trans_sched_pkg.sv | 23 ++
 rtl/hyper_trans_sched_if.sv | 57 +++++
 rtl/hyper_trans_sched_burst_calc.sv | 38 +++
 rtl/hyper_trans_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hyper_trans_sched_pkg.sv
// ---------------------------------------------------------------------------
// hyper_sched_pkg
// Shared types and constants for the HyperBus transaction scheduler:
//   sched_state_e  - scheduler FSM state encoding
//   MODE_*         - descriptor mode field values
//   REG_BURST_LEN  - fixed byte count of a register-space access
// ---------------------------------------------------------------------------
package hyper_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } sched_state_e;

  localparam logic [2:0] MODE_NORMAL = 3'h0;
  localparam logic [2:0] MODE_REG    = 3'h1;
  localparam logic [2:0] MODE_2D     = 3'h2;

  localparam int unsigned REG_BURST_LEN = 2;

endpackage

// File: rtl/hyper_trans_sched_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces of the HyperBus transaction scheduler.
//   hyper_trans_if : descriptor channel from the uDMA register block
//                    (master = register block, slave = scheduler)
//   hyper_phy_if   : burst request channel towards the PHY/command engine
//                    (master = scheduler, slave = PHY)
// Signal names keep the scheduler-side _i/_o direction suffixes.
// ---------------------------------------------------------------------------
interface hyper_trans_if #(
  parameter int TRANS_SIZE = 16,
  parameter int EXT_AWIDTH = 32
);
  logic                  trans_valid_i;
  logic                  trans_ready_o;
  logic [EXT_AWIDTH-1:0] trans_addr_i;
  logic [TRANS_SIZE-1:0] trans_size_i;
  logic                  trans_rwn_i;
  logic [2:0]            trans_mode_i;
  logic [TRANS_SIZE-1:0] stride_i;
  logic [TRANS_SIZE-1:0] line_i;
  logic [15:0]           cs_max_i;

  modport master (
    output trans_valid_i, trans_addr_i, trans_size_i, trans_rwn_i,
           trans_mode_i, stride_i, line_i, cs_max_i,
    input  trans_ready_o
  );

  modport slave (
    input  trans_valid_i, trans_addr_i, trans_size_i, trans_rwn_i,
           trans_mode_i, stride_i, line_i, cs_max_i,
    output trans_ready_o
  );
endinterface

interface hyper_phy_if #(
  parameter int TRANS_SIZE = 16,
  parameter int EXT_AWIDTH = 32
);
  logic                  phy_valid_o;
  logic                  phy_ready_i;
  logic [EXT_AWIDTH-1:0] phy_addr_o;
  logic [TRANS_SIZE-1:0] phy_len_o;
  logic                  phy_rwn_o;
  logic                  phy_reg_o;
  logic                  phy_done_i;

  modport master (
    output phy_valid_o, phy_addr_o, phy_len_o, phy_rwn_o, phy_reg_o,
    input  phy_ready_i, phy_done_i
  );

  modport slave (
    input  phy_valid_o, phy_addr_o, phy_len_o, phy_rwn_o, phy_reg_o,
    output phy_ready_i, phy_done_i
  );
endinterface

// File: rtl/hyper_trans_sched_burst_calc.sv
// ---------------------------------------------------------------------------
// hyper_burst_calc
// Combinational burst sizing: len = min(line_left, cs_max), with cs_max==0
// meaning unlimited; addr = line_base + offset (modulo 2^EXT_AWIDTH).
// Ports:
//   line_left_i  bytes left in the current line
//   cs_max_i     chip-select burst limit, 0 = unlimited
//   line_base_i  start address of the current line
//   offset_i     byte offset inside the current line
//   len_o        burst byte count
//   addr_o       burst start address
// ---------------------------------------------------------------------------
module hyper_burst_calc #(
  parameter int TRANS_SIZE = 16,
  parameter int EXT_AWIDTH = 32
) (
  input  logic [TRANS_SIZE-1:0] line_left_i,
  input  logic [15:0]           cs_max_i,
  input  logic [EXT_AWIDTH-1:0] line_base_i,
  input  logic [TRANS_SIZE-1:0] offset_i,
  output logic [TRANS_SIZE-1:0] len_o,
  output logic [EXT_AWIDTH-1:0] addr_o
);

  // Compare in a common width so any TRANS_SIZE works against the 16-bit limit.
  localparam int CW = (TRANS_SIZE > 16) ? TRANS_SIZE : 16;

  logic [CW-1:0] ll_w;
  logic [CW-1:0] cs_w;

  assign ll_w = CW'(line_left_i);
  assign cs_w = CW'(cs_max_i);

  // When cs_max wins it is smaller than line_left, so the narrowing is exact.
  assign len_o  = (cs_w == '0 || ll_w <= cs_w) ? line_left_i : TRANS_SIZE'(cs_w);
  assign addr_o = line_base_i + EXT_AWIDTH'(offset_i);

endmodule

// File: rtl/hyper_trans_sched.sv
// ---------------------------------------------------------------------------
// hyper_trans_sched
// Splits one uDMA transaction descriptor into PHY bursts bounded by the
// chip-select limit and, in 2D mode, by line ends; walks line base/offset.
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   trans          descriptor channel (slave)
//   phy            burst request channel (master)
//   busy_o         transaction in progress (state != IDLE)
//   done_o         one-cycle pulse at transaction end
//   abort_i        (HYPER_SCHED_ABORT_EN only) stop after the current burst
//   aborted_o      (HYPER_SCHED_ABORT_EN only) pulses with done_o on abort
// Build option: define HYPER_SCHED_ABORT_EN to add the abort ports.
//
// state | meaning
// IDLE  | ready for a descriptor
// CALC  | size next burst from line_left / cs_max
// ISSUE | phy_valid_o high, waiting for phy_ready_i
// WAIT  | burst accepted, waiting for phy_done_i
// ---------------------------------------------------------------------------
module hyper_trans_sched
  import hyper_sched_pkg::*;
#(
  parameter int TRANS_SIZE = 16,
  parameter int EXT_AWIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  hyper_trans_if.slave  trans,
  hyper_phy_if.master   phy,
  output logic          busy_o,
`ifdef HYPER_SCHED_ABORT_EN
  input  logic          abort_i,
  output logic          aborted_o,
`endif
  output logic          done_o
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_CALC  = CALC;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;

  logic [1:0]            state_q, state_d;
  logic                  rwn_q, rwn_d, reg_q, reg_d, done_q, done_d;
  logic [15:0]           cs_max_q, cs_max_d;
  logic [TRANS_SIZE-1:0] line_q, line_d, stride_q, stride_d;
  logic [TRANS_SIZE-1:0] offset_q, offset_d, remaining_q, remaining_d;
  logic [TRANS_SIZE-1:0] line_left_q, line_left_d, len_q, len_d;
  logic [EXT_AWIDTH-1:0] line_base_q, line_base_d, addr_q, addr_d;

  logic [TRANS_SIZE-1:0] calc_len, rem_nx, ll_nx, first_line, next_line;
  logic [EXT_AWIDTH-1:0] calc_addr;
  logic                  abort_req, abort_pend_q;

  hyper_burst_calc #(.TRANS_SIZE(TRANS_SIZE), .EXT_AWIDTH(EXT_AWIDTH)) u_calc (
    .line_left_i (line_left_q),
    .cs_max_i    (cs_max_q),
    .line_base_i (line_base_q),
    .offset_i    (offset_q),
    .len_o       (calc_len),
    .addr_o      (calc_addr)
  );

  assign first_line = (trans.line_i < trans.trans_size_i) ? trans.line_i : trans.trans_size_i;
  assign rem_nx     = remaining_q - len_q;
  assign ll_nx      = line_left_q - len_q;
  assign next_line  = (line_q < rem_nx) ? line_q : rem_nx;

  always_comb begin
    state_d     = state_q;
    rwn_d       = rwn_q;
    reg_d       = reg_q;
    cs_max_d    = cs_max_q;
    line_d      = line_q;
    stride_d    = stride_q;
    line_base_d = line_base_q;
    offset_d    = offset_q;
    remaining_d = remaining_q;
    line_left_d = line_left_q;
    len_d       = len_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trans.trans_valid_i) begin
          rwn_d       = trans.trans_rwn_i;
          reg_d       = (trans.trans_mode_i == MODE_REG);
          cs_max_d    = trans.cs_max_i;
          line_d      = trans.line_i;
          stride_d    = trans.stride_i;
          line_base_d = trans.trans_addr_i;
          offset_d    = '0;
          remaining_d = trans.trans_size_i;
          if (trans.trans_mode_i == MODE_2D && trans.line_i != '0)
            line_left_d = first_line;
          else
            line_left_d = trans.trans_size_i;
          if (trans.trans_mode_i == MODE_REG) begin
            // Register accesses are a single fixed-size burst; the CS limit does not apply.
            line_left_d = TRANS_SIZE'(REG_BURST_LEN);
            remaining_d = TRANS_SIZE'(REG_BURST_LEN);
            cs_max_d    = '0;
          end
          if (trans.trans_size_i == '0) done_d = 1'b1;
          else                          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (abort_req) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          len_d   = calc_len;
          addr_d  = calc_addr;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (phy.phy_ready_i) begin
          state_d = S_WAIT;
        end else if (abort_req) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (phy.phy_done_i) begin
          offset_d    = offset_q + len_q;
          line_left_d = ll_nx;
          remaining_d = rem_nx;
          if (rem_nx == '0 || abort_req || abort_pend_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            if (ll_nx == '0) begin
              line_base_d = line_base_q + EXT_AWIDTH'(stride_q);
              offset_d    = '0;
              line_left_d = next_line;
            end
            state_d = S_CALC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      rwn_q       <= 1'b0;
      reg_q       <= 1'b0;
      done_q      <= 1'b0;
      cs_max_q    <= '0;
      line_q      <= '0;
      stride_q    <= '0;
      line_base_q <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
      line_left_q <= '0;
      len_q       <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      rwn_q       <= rwn_d;
      reg_q       <= reg_d;
      done_q      <= done_d;
      cs_max_q    <= cs_max_d;
      line_q      <= line_d;
      stride_q    <= stride_d;
      line_base_q <= line_base_d;
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
      line_left_q <= line_left_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
    end
  end

`ifdef HYPER_SCHED_ABORT_EN
  logic aborted_q, abort_fire;

  assign abort_req = abort_i;

  // Abort terminations; a burst that finishes the transaction anyway counts as normal completion.
  assign abort_fire = (state_q == S_CALC  && abort_i) ||
                      (state_q == S_ISSUE && abort_i && !phy.phy_ready_i) ||
                      (state_q == S_WAIT  && phy.phy_done_i && (abort_i || abort_pend_q) &&
                       rem_nx != '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      aborted_q <= abort_fire;
      if (state_d == S_IDLE)
        abort_pend_q <= 1'b0;
      else if (abort_i && (state_q == S_ISSUE || state_q == S_WAIT))
        abort_pend_q <= 1'b1;
    end
  end

  assign aborted_o = aborted_q;
`else
  assign abort_req    = 1'b0;
  assign abort_pend_q = 1'b0;
`endif

  assign trans.trans_ready_o = (state_q == S_IDLE);
  assign phy.phy_valid_o     = (state_q == S_ISSUE);
  assign phy.phy_addr_o      = addr_q;
  assign phy.phy_len_o       = len_q;
  assign phy.phy_rwn_o       = rwn_q;
  assign phy.phy_reg_o       = reg_q;
  assign busy_o              = (state_q != S_IDLE);
  assign done_o              = done_q;

endmodule
